// File: rtl/i2cmb_cmd_sequencer.sv
// Wishbone master that expands byte-level I2C commands into iicmb_m_wb register accesses.
// Define I2CMB_CMD_SEQ_POLL_EN to poll CMDR for completion instead of waiting on irq_i.
module i2cmb_cmd_sequencer #(
  parameter int unsigned WB_ADDR_WIDTH  = 2,
  parameter int unsigned WB_DATA_WIDTH  = 8,
  parameter int unsigned NUM_I2C_BUSSES = 1,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [7:0]               cmd_data,
  output logic                     rsp_valid,
  output logic [4:0]               rsp_status,
  output logic [7:0]               rsp_data,
  output logic                     busy,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i,
  input  logic                     irq_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [WB_ADDR_WIDTH-1:0] AdrCsr  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] AdrDpr  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] AdrCmdr = WB_ADDR_WIDTH'(2);

`ifdef I2CMB_CMD_SEQ_POLL_EN
  localparam logic [7:0] CsrInit = 8'h80;
`else
  localparam logic [7:0] CsrInit = 8'hC0;
`endif

  localparam logic [2:0] OpWait    = 3'b000;
  localparam logic [2:0] OpWrite   = 3'b001;
  localparam logic [2:0] OpReadAck = 3'b010;
  localparam logic [2:0] OpReadNak = 3'b011;
  localparam logic [2:0] OpSetBus  = 3'b110;
  localparam logic [2:0] OpRsvd    = 3'b111;

  typedef enum logic [3:0] {
    StInitCsr,
    StIdle,
    StWrDpr,
    StWrCmdr,
    StWaitDone,
    StRdCmdr,
    StRdDpr,
    StRespond
  } state_e;

  state_e                   state_q, state_d;
  logic                     cyc_q, cyc_d;
  logic                     we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
  logic [2:0]               op_q, op_d;
  logic [7:0]               data_q, data_d;
  logic [4:0]               status_q, status_d;
  logic [7:0]               rdata_q, rdata_d;
  logic [CntW-1:0]          cnt_q, cnt_d;

  logic wb_done;
  logic is_read;
  logic cmd_illegal;
  logic unused_in;

  // Acks outside a cycle we issued never count.
  assign wb_done     = cyc_q && ack_i;
  assign is_read     = (op_q == OpReadAck) || (op_q == OpReadNak);
  assign cmd_illegal = (cmd_op == OpRsvd) ||
                       ((cmd_op == OpSetBus) && (32'(cmd_data) >= NUM_I2C_BUSSES));
  assign unused_in   = ^{dat_i, irq_i};

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    op_d     = op_q;
    data_d   = data_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;

    // Every cycle ends the edge after its ack; the low cycle that follows is the idle gap.
    if (wb_done) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      adr_d = '0;
      dat_d = '0;
    end

    unique case (state_q)
      StInitCsr: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = AdrCsr;
          dat_d = WB_DATA_WIDTH'(CsrInit);
        end else if (wb_done) begin
          state_d = StIdle;
        end
      end

      StIdle: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          data_d   = cmd_data;
          status_d = 5'b00000;
          rdata_d  = 8'h00;
          if (cmd_illegal) begin
            status_d = 5'b00001;
            state_d  = StRespond;
          end else if ((cmd_op == OpWrite) || (cmd_op == OpSetBus) || (cmd_op == OpWait)) begin
            state_d = StWrDpr;
          end else begin
            state_d = StWrCmdr;
          end
        end
      end

      StWrDpr: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = AdrDpr;
          dat_d = WB_DATA_WIDTH'(data_q);
        end else if (wb_done) begin
          state_d = StWrCmdr;
        end
      end

      StWrCmdr: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = AdrCmdr;
          dat_d = WB_DATA_WIDTH'({5'b00000, op_q});
        end else if (wb_done) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end
      end

      StWaitDone: begin
`ifdef I2CMB_CMD_SEQ_POLL_EN
        if (cnt_q != TimeoutLast) cnt_d = cnt_q + CntW'(1);
        if (wb_done && (dat_i[7:4] != 4'h0)) begin
          status_d = {1'b0, dat_i[7:4]};
          state_d  = (is_read && dat_i[7]) ? StRdDpr : StRespond;
        end else if (!cyc_q && (cnt_q == TimeoutLast)) begin
          status_d = 5'b10000;
          state_d  = StRespond;
        end else if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b0;
          adr_d = AdrCmdr;
          dat_d = '0;
        end
`else
        if (irq_i) begin
          state_d = StRdCmdr;
        end else if (cnt_q == TimeoutLast) begin
          status_d = 5'b10000;
          state_d  = StRespond;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end

      StRdCmdr: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b0;
          adr_d = AdrCmdr;
          dat_d = '0;
        end else if (wb_done) begin
          status_d = {1'b0, dat_i[7:4]};
          state_d  = (is_read && dat_i[7]) ? StRdDpr : StRespond;
        end
      end

      StRdDpr: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b0;
          adr_d = AdrDpr;
          dat_d = '0;
        end else if (wb_done) begin
          rdata_d = dat_i[7:0];
          state_d = StRespond;
        end
      end

      StRespond: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StInitCsr;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StInitCsr;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      op_q     <= 3'b000;
      data_q   <= 8'h00;
      status_q <= 5'b00000;
      rdata_q  <= 8'h00;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      op_q     <= op_d;
      data_q   <= data_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign rsp_valid  = (state_q == StRespond);
  assign rsp_status = status_q;
  assign rsp_data   = rdata_q;
  assign cyc_o      = cyc_q;
  assign stb_o      = cyc_q;
  assign we_o       = we_q;
  assign adr_o      = adr_q;
  assign dat_o      = dat_q;

endmodule

// File: doc/i2cmb_cmd_sequencer.md
Name: i2cmb_cmd_sequencer

Overview:
Synthesizable Wishbone master that drives the iicmb_m_wb register interface on behalf of a simple command/response stream.
- Accepts byte-level I2C operations (start, stop, write, read, set bus, wait).
- Expands each operation into the required CSR/DPR/CMDR register accesses.
- Waits for completion and returns the CMDR status plus any read byte.
- Sits between on-chip logic and the I2C multi-bus controller, replacing the bench-only Wishbone BFM in multi-bus systems.

Parameters:
WB_ADDR_WIDTH, 2, Wishbone address width; register map uses addresses 0-3.
WB_DATA_WIDTH, 8, Wishbone data width; must be at least 8.
NUM_I2C_BUSSES, 1, number of controller busses; bounds legal SET_BUS values.
TIMEOUT_CYCLES, 65535, maximum clk_i cycles spent waiting for command completion.

Ports:
clk_i  in  1  system clock; all logic on rising edge
rst_i  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer accepts command; high only in IDLE
cmd_op  in  3  000 WAIT, 001 WRITE, 010 READ_ACK, 011 READ_NAK, 100 START, 101 STOP, 110 SET_BUS, 111 reserved
cmd_data  in  8  write byte, bus id, or wait ms
rsp_valid  out  1  one-cycle pulse per completed command
rsp_status  out  5  {TIMEOUT, DON, NAK, AL, ERR}
rsp_data  out  8  DPR byte for reads, else 0
busy  out  1  high in any state except IDLE
cyc_o, stb_o, we_o  out  1 each  Wishbone master controls
adr_o  out  WB_ADDR_WIDTH  register address
dat_o  out  WB_DATA_WIDTH  write data
dat_i  in  WB_DATA_WIDTH  read data
ack_i  in  1  slave acknowledge
irq_i  in  1  controller interrupt

Behaviour:
- Reset values: cmd_ready 0, rsp_valid 0, rsp_status 0, rsp_data 0, busy 1, cyc_o/stb_o/we_o 0, adr_o 0, dat_o 0.
- Wishbone cycle rules:
  - Drive cyc_o, stb_o, adr_o, we_o and dat_o together.
  - Hold them until the first clk_i with ack_i=1.
  - Deassert on the following cycle.
  - Minimum one idle cycle between cycles.
  - Only one cycle outstanding at a time.
- Sequence states: INIT_CSR -> IDLE -> [WR_DPR] -> WR_CMDR -> WAIT_DONE -> RD_CMDR -> [RD_DPR] -> RESPOND -> IDLE.
- INIT_CSR: after reset, write CSR (adr 0) = 0xC0 (enable + IE), then enter IDLE.
- IDLE: cmd_ready=1. Accept a command when cmd_valid and cmd_ready are both high; latch cmd_op and cmd_data.
- WR_DPR: taken for WRITE, SET_BUS and WAIT. Writes cmd_data to DPR (adr 1).
- WR_CMDR: writes {5'b0, cmd_op} to CMDR (adr 2).
- WAIT_DONE:
  - Waits for irq_i=1.
  - Counter starts at 0 on entry.
  - If the counter reaches TIMEOUT_CYCLES, go to RESPOND with status 5'b10000 and skip the register reads.
- RD_CMDR: read CMDR; latch dat_i[7:4] into rsp_status[3:0]. The read clears irq in the controller.
- RD_DPR: taken only for READ_ACK and READ_NAK when DON=1. Latches dat_i[7:0] into rsp_data.
- RESPOND: rsp_valid=1 for exactly one cycle. rsp_status and rsp_data hold until the next accepted command.
- Illegal SET_BUS: cmd_data >= NUM_I2C_BUSSES gives no Wishbone activity; respond with status 5'b00001 (ERR) after one cycle.
- Reserved opcode 111: same handling as illegal SET_BUS (ERR, no bus activity).
- cmd_valid deasserted while busy is ignored; commands are never queued.
- rst_i mid-operation:
  - Abandon the current Wishbone cycle on the next edge (cyc_o/stb_o low).
  - Drop any pending response.
  - Re-run INIT_CSR.
- ack_i during a cycle the sequencer did not issue is ignored.

Optional Feature:
I2CMB_CMD_SEQ_POLL_EN
- Defined:
  - WAIT_DONE ignores irq_i.
  - INIT_CSR writes 0x80 (IE clear).
  - WAIT_DONE repeatedly reads CMDR, with one idle cycle between reads, until any of bits 7:4 is set. That read supplies the status and RD_CMDR is skipped.
  - The timeout counter still applies.
- Undefined: interrupt-driven behaviour as specified above.

Test Plan:
- Reset release -> first Wishbone cycle is write adr 0 data 0xC0; cmd_ready rises only after its ack.
- START, then WRITE 0x44 with slave addr ack -> writes adr2=0x04; then adr1=0x44, adr2=0x01; rsp_status 5'b01000 for each command; rsp_data 0x00.
- READ_NAK with BFM returning 0xA5 -> adr2=0x03, read CMDR 0x80, read DPR; rsp_data 0xA5, status 5'b01000.
- WRITE to absent address (BFM NAK) -> status 5'b00100; no DPR read.
- SET_BUS 2 with NUM_I2C_BUSSES=2 -> ERR 5'b00001 with zero cyc_o activity. SET_BUS 1 -> adr1=0x01, adr2=0x06, DON.
- irq_i held low, TIMEOUT_CYCLES=100 -> rsp_valid exactly 100 cycles after WAIT_DONE entry with 5'b10000. Assert rst_i mid-WR_CMDR -> cyc_o low next edge; CSR write repeats.
